// File: rtl/ofdm_cp_remover.sv
// rtl/ofdm_cp_remover.sv - strips the cyclic prefix from each OFDM symbol and
// forwards the FFT body with sop/eop framing through a 2-entry skid buffer.
module ofdm_cp_remover #(
  parameter int DATA_W  = 14,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_sop,
  output logic                in_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  input  logic                out_ready,
  output logic                sync_err,
  output logic [15:0]         sym_count
);

  localparam int DW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] FFT_LAST = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              sync_err_q, sync_err_d;
  logic [15:0]       sym_count_q, sym_count_d;

  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;

  logic              skid_valid_q, skid_valid_d;
  logic [DW-1:0]     skid_data_q, skid_data_d;
  logic              skid_sop_q, skid_sop_d;
  logic              skid_eop_q, skid_eop_d;

  logic              accept;
  logic              push;
  logic              push_sop;
  logic              push_eop;
  logic              out_fire;

  assign accept   = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Framing FSM. In CP, cnt==0 only occurs right after an eop, where the
  // next beat must carry in_sop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    push_sop   = 1'b0;
    push_eop   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_sop) begin
            if (CP_LEN > 1) begin
              state_d = CP;
              cnt_d   = CNT_ONE;
            end else begin
              state_d = BODY;
              cnt_d   = '0;
            end
          end
        end
        CP: begin
          if (cnt_q == '0) begin
            if (!in_sop) begin
              sync_err_d = 1'b1;
              state_d    = IDLE;
              cnt_d      = '0;
            end else if (CP_LEN > 1) begin
              cnt_d = CNT_ONE;
            end else begin
              state_d = BODY;
              cnt_d   = '0;
            end
          end else if (in_sop) begin
            sync_err_d = 1'b1;
            cnt_d      = CNT_ONE;
          end else if (cnt_q == CP_LAST) begin
            state_d = BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BODY: begin
          if (in_sop && (cnt_q != '0)) begin
            // Abandon the partial symbol; this beat restarts the prefix.
            sync_err_d = 1'b1;
            if (CP_LEN > 1) begin
              state_d = CP;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d = '0;
            end
          end else begin
            push     = 1'b1;
            push_sop = (cnt_q == '0);
            push_eop = (cnt_q == FFT_LAST);
            if (cnt_q == FFT_LAST) begin
              state_d = CP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output register plus skid register. A push never coincides with a full
  // skid because in_ready mirrors the skid being empty.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_sop_d   = push_sop;
        out_eop_d   = push_eop;
      end else begin
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_sop_d   = push_sop;
      skid_eop_d   = push_eop;
    end
    in_ready_d  = !skid_valid_d;
    sym_count_d = sym_count_q + ((out_fire && out_eop_q) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      sym_count_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      sync_err_q   <= sync_err_d;
      sym_count_q  <= sym_count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign sync_err  = sync_err_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// tb/tb_ofdm_cp_remover.sv - directed table-driven bench for ofdm_cp_remover.
module tb_ofdm_cp_remover;

  localparam int DATA_W = 14;
  localparam int DW     = 2 * DATA_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;
  logic          sync_err;
  logic [15:0]   sym_count;

  logic tog = 1'b0;
  logic toggle_mode = 1'b0;
  logic ready_fix = 1'b1;
  assign out_ready = toggle_mode ? tog : ready_fix;

  ofdm_cp_remover #(.DATA_W(14), .FFT_LEN(64), .CP_LEN(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .sync_err(sync_err), .sym_count(sym_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end

  int   cyc = 0;
  logic rst_d = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  int checks = 0;
  int failures = 0;

  logic [29:0] got_q[$];
  logic [29:0] exp_q[$];
  int err_cnt = 0;
  int err_cyc = -1;
  int stab_viol = 0;
  int rdy_viol = 0;
  int last_acc_cyc = 0;
  logic prev_stall = 1'b0;
  logic [29:0] prev_beat = '0;

  always @(negedge clk) begin
    if (rst_d || reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || ({out_sop, out_eop, out_data} != prev_beat))) stab_viol++;
      if (!in_ready && !out_valid) rdy_viol++;
      if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_data});
      if (sync_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_sop, out_eop, out_data};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    err_cnt   = 0;
    err_cyc   = -1;
    stab_viol = 0;
    rdy_viol  = 0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sop", 32'(out_sop), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic sop, input bit gaps);
    logic acc;
    int   n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_data  = d;
    in_sop   = sop;
    in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    last_acc_cyc = cyc;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk(input int sym, input int idx);
    logic [13:0] s;
    logic [13:0] i;
    s = sym[13:0];
    i = idx[13:0];
    return {s, i};
  endfunction

  task automatic send_sym(input int sym, input int first, input int last, input bit with_sop, input bit gaps);
    for (int idx = first; idx <= last; idx++)
      send_beat(mk(sym, idx), (idx == 0) && with_sop, gaps);
  endtask

  task automatic expect_sym(input int sym, input int first, input int last);
    for (int idx = first; idx <= last; idx++)
      exp_q.push_back({(idx == 16), (idx == 79), mk(sym, idx)});
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got out_valid=1 after %0d cycles expected 0", n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    int mism;
    int first_bad;
    mism = 0;
    first_bad = -1;
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0)
      $display("  %s first difference at beat %0d: got %h expected %h", tag, first_bad,
               got_q[first_bad], exp_q[first_bad]);
    check({tag, "_beat_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_hold_violations"}, 32'(stab_viol), 32'd0);
    check({tag, "_in_ready_violations"}, 32'(rdy_viol), 32'd0);
  endtask

  typedef struct {
    string name;
    int    start_idx;
    int    nsym;
    bit    toggle;
    bit    gaps;
    int    exp_beats;
    int    exp_syms;
  } scn_t;

  initial begin
    scn_t tbl[4];
    int   off_cyc;
    tbl[0] = '{"b2b", 0, 3, 1'b0, 1'b0, 192, 3};
    tbl[1] = '{"stall", 0, 3, 1'b1, 1'b1, 192, 3};
    tbl[2] = '{"midstart", 40, 3, 1'b0, 1'b0, 128, 2};
    tbl[3] = '{"gaps", 0, 2, 1'b0, 1'b1, 128, 2};

    for (int t = 0; t < 4; t++) begin
      do_reset();
      clear_logs();
      toggle_mode = tbl[t].toggle;
      ready_fix   = 1'b1;
      send_sym(0, tbl[t].start_idx, 79, 1'b1, tbl[t].gaps);
      if (tbl[t].start_idx == 0) expect_sym(0, 16, 79);
      for (int s = 1; s < tbl[t].nsym; s++) begin
        send_sym(s, 0, 79, 1'b1, tbl[t].gaps);
        expect_sym(s, 16, 79);
      end
      drain();
      toggle_mode = 1'b0;
      compare_out(tbl[t].name);
      check({tbl[t].name, "_table_beats"}, 32'(got_q.size()), 32'(tbl[t].exp_beats));
      check({tbl[t].name, "_sym_count"}, 32'(sym_count), 32'(tbl[t].exp_syms));
      check({tbl[t].name, "_sync_err_pulses"}, 32'(err_cnt), 32'd0);
    end

    // in_sop arrives at sample index 30, inside the body
    do_reset();
    clear_logs();
    send_sym(0, 0, 29, 1'b1, 1'b0);
    expect_sym(0, 16, 29);
    send_beat(mk(1, 0), 1'b1, 1'b0);
    off_cyc = last_acc_cyc;
    send_sym(1, 1, 79, 1'b1, 1'b0);
    expect_sym(1, 16, 79);
    send_sym(2, 0, 79, 1'b1, 1'b0);
    expect_sym(2, 16, 79);
    drain();
    compare_out("early_sop");
    check("early_sop_err_pulses", 32'(err_cnt), 32'd1);
    check("early_sop_err_cycle", 32'(err_cyc), 32'(off_cyc));
    check("early_sop_sym_count", 32'(sym_count), 32'd2);

    // symbol after an eop arrives without in_sop
    do_reset();
    clear_logs();
    send_sym(0, 0, 79, 1'b1, 1'b0);
    expect_sym(0, 16, 79);
    send_beat(mk(1, 0), 1'b0, 1'b0);
    off_cyc = last_acc_cyc;
    send_sym(1, 1, 79, 1'b0, 1'b0);
    send_sym(2, 0, 79, 1'b1, 1'b0);
    expect_sym(2, 16, 79);
    drain();
    compare_out("missing_sop");
    check("missing_sop_err_pulses", 32'(err_cnt), 32'd1);
    check("missing_sop_err_cycle", 32'(err_cyc), 32'(off_cyc));
    check("missing_sop_sym_count", 32'(sym_count), 32'd2);

    // reset while both output registers hold body beats
    do_reset();
    clear_logs();
    send_sym(0, 0, 79, 1'b1, 1'b0);
    drain();
    check("pre_reset_sym_count", 32'(sym_count), 32'd1);
    ready_fix = 1'b0;
    send_sym(1, 0, 17, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_out_sop", 32'(out_sop), 32'd1);
    check("full_out_data", 32'(out_data), 32'(mk(1, 16)));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_sym_count", 32'(sym_count), 32'd0);
    reset = 1'b0;
    ready_fix = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    send_sym(2, 0, 79, 1'b1, 1'b0);
    expect_sym(2, 16, 79);
    drain();
    compare_out("post_reset");
    check("post_reset_sym_count", 32'(sym_count), 32'd1);
    check("post_reset_err_pulses", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 expected earlier finish");
    $fatal(1);
  end

endmodule

// File: doc/ofdm_cp_remover.md
Name: ofdm_cp_remover

Overview:
- Receive-side counterpart of the OFDM cyclic-prefix adder.
- Takes a continuous Avalon-ST stream of I/Q symbols, each CP_LEN+FFT_LEN samples, with the symbol start marked by in_sop.
- Discards the CP_LEN prefix samples and forwards the FFT_LEN body samples to the FFT with out_sop/out_eop framing.
- Tracks symbol alignment, flags framing errors, and absorbs downstream backpressure with a 2-entry skid buffer.

Parameters:
- DATA_W, 14, width of each I and Q component (matches the 14-bit DAC path).
- FFT_LEN, 64, body samples per symbol; must be >= 2.
- CP_LEN, 16, prefix samples per symbol; must be >= 1.
- CNT_W, 8, sample counter width; must hold max(FFT_LEN, CP_LEN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  2*DATA_W  sample, {I[DATA_W-1:0], Q[DATA_W-1:0]}.
- in_valid  in  1  sink beat valid.
- in_sop  in  1  marks first CP sample of a symbol.
- in_ready  out  1  sink ready; registered.
- out_data  out  2*DATA_W  body sample.
- out_valid  out  1  source beat valid.
- out_sop  out  1  first body sample.
- out_eop  out  1  last body sample (FFT_LEN-th).
- out_ready  in  1  downstream ready.
- sync_err  out  1  one-cycle pulse on a framing error.
- sym_count  out  16  count of completed symbols (out_eop handshakes); wraps at 16 bits.

Behaviour:
- Decided interface rules: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE, cnt=0, skid buffer emptied, in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, sync_err=0, sym_count=0. in_ready rises the cycle after reset deasserts.
- Handshake: input beat accepted when in_valid&in_ready. Output beat transferred when out_valid&out_ready.
- in_ready: registered, = skid register empty. Deasserts only when both output registers are occupied.
- Output path: main output register + skid register. Latency is 1 cycle from accepted body beat to out_valid when not stalled. Order is preserved. out_data, out_sop, out_eop hold stable while out_valid&!out_ready.
- FSM states IDLE, CP, BODY. Counter cnt is CNT_W bits.
- IDLE: accepted beats discarded. Beat with in_sop=1 → cnt=1. Then go CP if CP_LEN>1, else BODY with cnt=0.
- CP: accepted beats discarded, cnt++. When the beat at cnt==CP_LEN-1 is accepted → BODY, cnt=0.
- BODY: accepted beat pushed to output path. out_sop=(cnt==0), out_eop=(cnt==FFT_LEN-1). On the eop beat → CP_EXPECT, i.e. CP state with cnt=0 requiring in_sop on the next beat.
- Boundary: first accepted beat after an eop has in_sop=0 → sync_err pulse, beat discarded, state=IDLE.
- Boundary: in_sop=1 during CP at cnt!=0 → sync_err pulse; beat treated as new CP sample 0 (cnt=1).
- Boundary: in_sop=1 during BODY (cnt!=0) → sync_err pulse; beat treated as CP sample 0 (cnt=1, state CP). The partial symbol already forwarded ends without out_eop; the downstream consumer resynchronises on out_sop.
- Counting: cnt advances only on accepted beats. in_valid=0 gaps are transparent.
- sym_count increments on an out_eop handshake, not on acceptance; wraps 0xFFFF→0.
- sync_err: registered, asserted exactly the cycle after the offending beat is accepted.
- Reset mid-symbol: all state discarded within the reset cycle; any buffered output beats are lost.

Test Plan:
- FFT_LEN=64, CP_LEN=16. 3 back-to-back symbols, sample value = index 0..79 within each symbol, in_sop on index 0, out_ready=1 → exactly 192 out beats with values 16..79 repeated; out_sop on 16, out_eop on 79; sym_count=3; sync_err never set.
- Same stream with out_ready toggled 1-0-1 every cycle and random in_valid gaps → identical output sequence, no loss or duplication; in_ready falls only when both registers are full; sym_count=3.
- Stream starting at index 40 of a symbol (no in_sop) → first 40 beats dropped in IDLE; output begins with the next symbol's sample 16 carrying out_sop; sync_err=0.
- in_sop injected at body index 30 → sync_err one pulse; 14 beats (16..29) emitted with no eop; the new symbol is then output correctly; sym_count counts only complete symbols.
- After an eop, next beat has in_sop=0 → sync_err pulse, IDLE, no output until the next in_sop.
- reset asserted mid-body with out_ready=0 → the next cycle shows out_valid=0, in_ready=0, sym_count=0; a fresh symbol then processes normally.
